regfile_port_arbiter: RTL and testbench

//  Sequences the 4-write/4-read multi-port register file on a single clock.

---
 rtl/regfile_port_arbiter_pkg.sv | 8 +
 rtl/regfile_port_arbiter_if.sv | 27 ++
 rtl/regfile_port_arbiter_rr_pick4.sv | 15 +
 rtl/regfile_port_arbiter.sv | 84 ++++++++
 tb/tb_regfile_port_arbiter.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/regfile_port_arbiter_pkg.sv
// regfile_port_arbiter_pkg: shared port count, FSM state encoding and one-hot helper for the register file arbiter
package regfile_arb_pkg;
  localparam int NUM_PORTS = 4;
  typedef enum logic [1:0] {ST_IDLE, ST_WRITE, ST_READ, ST_READ_WAIT} state_e;
  function automatic logic [NUM_PORTS-1:0] onehot(input logic [1:0] idx);
    return NUM_PORTS'(1) << idx;
  endfunction
endpackage

// File: rtl/regfile_port_arbiter_if.sv
// regfile_port_arbiter_if: client handshakes plus register file control pins, master = clients, slave = arbiter
interface regfile_port_arbiter_if
  import regfile_arb_pkg::*;
#(parameter int ADDR_W = 2);
  logic [NUM_PORTS-1:0]        wrReq;
  logic [NUM_PORTS*ADDR_W-1:0] wrAddr;
  logic [NUM_PORTS-1:0]        wrAck;
  logic                        rdReq;
  logic [NUM_PORTS*ADDR_W-1:0] rdAddr;
  logic                        rdAck;
  logic                        rdValid;
  logic                        rfWriteEnable;
  logic                        rfReadEnable;
  logic [NUM_PORTS-1:0]        rfWritePortEnable;
  logic [ADDR_W-1:0]           rfWritePortSelect;
  logic [NUM_PORTS*ADDR_W-1:0] rfReadSelect;
  modport master (
    output wrReq, wrAddr, rdReq, rdAddr,
    input  wrAck, rdAck, rdValid, rfWriteEnable, rfReadEnable,
           rfWritePortEnable, rfWritePortSelect, rfReadSelect
  );
  modport slave (
    input  wrReq, wrAddr, rdReq, rdAddr,
    output wrAck, rdAck, rdValid, rfWriteEnable, rfReadEnable,
           rfWritePortEnable, rfWritePortSelect, rfReadSelect
  );
endinterface

// File: rtl/regfile_port_arbiter_rr_pick4.sv
// rr_pick4: combinational round-robin picker; first requester at or after ptr (mod 4) wins
module rr_pick4 (
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic [3:0] gnt,
  output logic       any
);
  logic [3:0] rot, pick;
  always_comb begin
    rot = 4'({req, req} >> ptr);
    pick = rot & (~rot + 4'd1);
    gnt = 4'(({pick, pick} << ptr) >> 4);
    any = |req;
  end
endmodule

// File: rtl/regfile_port_arbiter.sv
// regfile_port_arbiter: one write or one quad read per cycle onto the register file, all control pins from flops.
// REGARB_STARVE_GUARD_EN builds the burst counter that lets a waiting read in after MAX_WRITE_BURST writes.
module regfile_port_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int WIDTH           = 8,
  parameter int ADDR_W          = 2,
  parameter int MAX_WRITE_BURST = 4
) (
  input logic clock,
  input logic reset,
  regfile_port_arbiter_if.slave bus
);
  if (WIDTH < 1 || ADDR_W < 1 || MAX_WRITE_BURST < 1) begin : g_bad_cfg
    $error("regfile_port_arbiter: bad parameters");
  end
  state_e state_q, state_d;
  logic [NUM_PORTS-1:0] wr_ack_q, wr_ack_d, wr_gnt, wr_elig, rf_wpe_q, rf_wpe_d;
  logic [ADDR_W-1:0] rf_wps_q, rf_wps_d;
  logic [NUM_PORTS*ADDR_W-1:0] rf_rs_q, rf_rs_d;
  logic [1:0] rr_ptr_q, rr_ptr_d, w;
  logic rd_ack_q, rd_ack_d, rd_valid_q, rd_valid_d, rf_we_q, rf_we_d, rf_re_q, rf_re_d;
  logic wr_any, rd_sel, wr_sel, starved;
  // an acked client is masked for one edge so it is never re-granted while dropping its request
  assign wr_elig = bus.wrReq & ~wr_ack_q;
  rr_pick4 u_pick (.req(wr_elig), .ptr(rr_ptr_q), .gnt(wr_gnt), .any(wr_any));
`ifdef REGARB_STARVE_GUARD_EN
  localparam int BW = $clog2(MAX_WRITE_BURST + 1);
  logic [BW-1:0] burst_q, burst_d;
  assign starved = burst_q == BW'(MAX_WRITE_BURST);
  always_comb burst_d = (!bus.rdReq || rd_sel) ? '0 : (wr_sel && !starved) ? burst_q + 1'b1 : burst_q;
  always_ff @(posedge clock) burst_q <= !reset ? '0 : burst_d;
`else
  assign starved = 1'b0;
`endif
  always_comb begin
    w = '0;
    for (int i = 0; i < NUM_PORTS; i++) if (wr_gnt[i]) w = 2'(i);
    rd_sel = bus.rdReq && (state_q == ST_IDLE || state_q == ST_WRITE) && (!wr_any || starved);
    wr_sel = state_q != ST_READ && wr_any && !rd_sel;
    state_d = state_q == ST_READ ? ST_READ_WAIT : rd_sel ? ST_READ : wr_sel ? ST_WRITE : ST_IDLE;
    rr_ptr_d = wr_sel ? w + 2'd1 : rr_ptr_q;
    wr_ack_d = wr_sel ? onehot(w) : '0;
    rf_we_d = wr_sel;
    rf_wpe_d = wr_ack_d;
    rf_wps_d = wr_sel ? bus.wrAddr[w*ADDR_W +: ADDR_W] : '0;
    rd_ack_d = rd_sel;
    rf_re_d = rd_sel;
    rf_rs_d = rd_sel ? bus.rdAddr : '0;
    rd_valid_d = state_q == ST_READ;
  end
  always_ff @(posedge clock)
    if (!reset) begin
      state_q <= ST_IDLE;
      rr_ptr_q <= '0;
      wr_ack_q <= '0;
      rf_we_q <= 1'b0;
      rf_wpe_q <= '0;
      rf_wps_q <= '0;
      rd_ack_q <= 1'b0;
      rf_re_q <= 1'b0;
      rf_rs_q <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_ptr_q <= rr_ptr_d;
      wr_ack_q <= wr_ack_d;
      rf_we_q <= rf_we_d;
      rf_wpe_q <= rf_wpe_d;
      rf_wps_q <= rf_wps_d;
      rd_ack_q <= rd_ack_d;
      rf_re_q <= rf_re_d;
      rf_rs_q <= rf_rs_d;
      rd_valid_q <= rd_valid_d;
    end
  assign bus.wrAck = wr_ack_q;
  assign bus.rdAck = rd_ack_q;
  assign bus.rdValid = rd_valid_q;
  assign bus.rfWriteEnable = rf_we_q;
  assign bus.rfReadEnable = rf_re_q;
  assign bus.rfWritePortEnable = rf_wpe_q;
  assign bus.rfWritePortSelect = rf_wps_q;
  assign bus.rfReadSelect = rf_rs_q;
endmodule

// File: tb/tb_regfile_port_arbiter.sv
// tb_regfile_port_arbiter: vector table, directed corner sequences and random traffic against a behavioural model
module tb_regfile_port_arbiter;
  localparam int MAXB = 4;
`ifdef REGARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif
  typedef struct packed {
    logic [3:0] wr_ack; logic rd_ack, rd_valid, we, re;
    logic [3:0] wpe; logic [1:0] wps; logic [7:0] rs;
  } obs_t;
  typedef struct packed {
    logic [3:0] wr_req; logic [7:0] wr_addr; logic rd_req; logic [7:0] rd_addr;
    logic [3:0] wr_ack; logic rd_ack, rd_valid; logic [1:0] wps; logic [7:0] rs;
  } vec_t;
  logic clock = 1'b0, reset = 1'b0;
  int pass_n = 0, total_n = 0;
  regfile_port_arbiter_if #(.ADDR_W(2)) bus ();
  regfile_port_arbiter #(.WIDTH(8), .ADDR_W(2), .MAX_WRITE_BURST(MAXB)) dut (.clock(clock), .reset(reset), .bus(bus));
  always #5 clock = ~clock;
  logic [7:0] wr_data [4];
  logic [7:0] mem [4];
  logic [7:0] rd_line [4];
  // register file stand-in: writes and registered reads on the rising edge
  always @(posedge clock) begin
    for (int p = 0; p < 4; p++) if (bus.rfWriteEnable && bus.rfWritePortEnable[p]) mem[bus.rfWritePortSelect] <= wr_data[p];
    if (bus.rfReadEnable) for (int k = 0; k < 4; k++) rd_line[k] <= mem[bus.rfReadSelect[k*2 +: 2]];
  end
  obs_t exp_o = '0;
  int m_ptr = 0, m_phase = 0, m_burst = 0;
  // reference model: m_phase 0 = free, 1 = read issued, 2 = data returning
  always @(posedge clock) begin
    obs_t n; int pick, c; bit do_rd;
    n = '0; pick = -1; do_rd = 0;
    if (!reset) begin
      m_ptr = 0; m_phase = 0; m_burst = 0;
    end else if (m_phase == 1) begin
      n.rd_valid = 1'b1; m_phase = 2;
      if (!bus.rdReq) m_burst = 0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        c = (m_ptr + k) % 4;
        if (pick < 0 && bus.wrReq[c] && !exp_o.wr_ack[c]) pick = c;
      end
      do_rd = bus.rdReq && m_phase == 0 && (pick < 0 || (GUARD && m_burst == MAXB));
      if (do_rd) begin
        n.rd_ack = 1'b1; n.re = 1'b1; n.rs = bus.rdAddr; m_phase = 1;
      end else begin
        m_phase = 0;
        if (pick >= 0) begin
          n.wr_ack[pick] = 1'b1; n.wpe[pick] = 1'b1; n.we = 1'b1;
          n.wps = bus.wrAddr[pick*2 +: 2]; m_ptr = (pick + 1) % 4;
        end
      end
      if (!bus.rdReq || do_rd) m_burst = 0;
      else if (pick >= 0 && m_burst < MAXB) m_burst++;
    end
    exp_o = n;
  end
  function automatic obs_t dut_obs();
    return {bus.wrAck, bus.rdAck, bus.rdValid, bus.rfWriteEnable, bus.rfReadEnable,
            bus.rfWritePortEnable, bus.rfWritePortSelect, bus.rfReadSelect};
  endfunction
  function automatic obs_t vec_exp(vec_t v);
    return {v.wr_ack, v.rd_ack, v.rd_valid, |v.wr_ack, v.rd_ack, v.wr_ack, v.wps, v.rs};
  endfunction
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    total_n++;
    if (act === want) pass_n++;
    else $display("FAIL %s: got %h, expected %h", name, act, want);
  endtask
  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask
  task automatic idle_inputs();
    bus.wrReq = '0; bus.wrAddr = '0; bus.rdReq = 1'b0; bus.rdAddr = '0;
  endtask
  vec_t tbl [13];
  int writes;
  bit got;
  initial begin
    tbl = '{
      {4'b0100, 8'h30, 1'b0, 8'h00, 4'b0100, 1'b0, 1'b0, 2'd3, 8'h00},
      {4'b0000, 8'h00, 1'b0, 8'h00, 4'b0000, 1'b0, 1'b0, 2'd0, 8'h00},
      {4'b1001, 8'h81, 1'b0, 8'h00, 4'b1000, 1'b0, 1'b0, 2'd2, 8'h00},
      {4'b0001, 8'h01, 1'b0, 8'h00, 4'b0001, 1'b0, 1'b0, 2'd1, 8'h00},
      {4'b0000, 8'h00, 1'b1, 8'hE4, 4'b0000, 1'b1, 1'b0, 2'd0, 8'hE4},
      {4'b0000, 8'h00, 1'b0, 8'h00, 4'b0000, 1'b0, 1'b1, 2'd0, 8'h00},
      {4'b0010, 8'h08, 1'b0, 8'h00, 4'b0010, 1'b0, 1'b0, 2'd2, 8'h00},
      {4'b0010, 8'h08, 1'b1, 8'h1B, 4'b0000, 1'b1, 1'b0, 2'd0, 8'h1B},
      {4'b0010, 8'h08, 1'b1, 8'h1B, 4'b0000, 1'b0, 1'b1, 2'd0, 8'h00},
      {4'b0010, 8'h08, 1'b1, 8'h1B, 4'b0010, 1'b0, 1'b0, 2'd2, 8'h00},
      {4'b0000, 8'h00, 1'b1, 8'h1B, 4'b0000, 1'b1, 1'b0, 2'd0, 8'h1B},
      {4'b0000, 8'h00, 1'b0, 8'h00, 4'b0000, 1'b0, 1'b1, 2'd0, 8'h00},
      {4'b0000, 8'h00, 1'b0, 8'h00, 4'b0000, 1'b0, 1'b0, 2'd0, 8'h00}
    };
    for (int i = 0; i < 4; i++) wr_data[i] = 8'(i * 8'h11);
    idle_inputs();
    @(negedge clock);
    tick(); tick();
    check("reset_outputs", dut_obs(), 0);
    reset = 1'b1;
    for (int i = 0; i < 13; i++) begin
      bus.wrReq = tbl[i].wr_req; bus.wrAddr = tbl[i].wr_addr;
      bus.rdReq = tbl[i].rd_req; bus.rdAddr = tbl[i].rd_addr;
      tick();
      check($sformatf("vec%0d", i), dut_obs(), vec_exp(tbl[i]));
    end
    bus.rdReq = 1'b1; bus.rdAddr = 8'hE4;
    tick();
    check("midread_ack", bus.rdAck, 1);
    reset = 1'b0; bus.rdReq = 1'b0;
    tick();
    check("reset_a", dut_obs(), 0);
    tick();
    check("reset_b_no_valid", dut_obs(), 0);
    reset = 1'b1; bus.wrReq = 4'b1111; bus.wrAddr = 8'hE4;
    for (int j = 0; j < 4; j++) begin
      tick();
      check($sformatf("rr_seq%0d", j), bus.wrAck, 32'(1 << j));
      bus.wrReq = bus.wrReq & ~bus.wrAck;
    end
    idle_inputs();
    tick();
    bus.wrReq = 4'b0100; bus.wrAddr = 8'h30; wr_data[2] = 8'hA5;
    tick();
    check("wr_a5_ack", bus.wrAck, 4'b0100);
    bus.wrReq = '0; bus.rdReq = 1'b1; bus.rdAddr = 8'hFF;
    tick();
    check("rd_a5_ack", {bus.rdAck, bus.rdValid}, 2'b10);
    bus.rdReq = 1'b0;
    tick();
    check("rd_a5_valid", bus.rdValid, 1);
    check("rd_a5_lines", {rd_line[0], rd_line[1], rd_line[2], rd_line[3]}, 32'hA5A5A5A5);
    idle_inputs();
    tick();
    bus.wrReq = 4'b1111; bus.wrAddr = 8'hE4; bus.rdReq = 1'b1; bus.rdAddr = 8'h55;
    writes = 0; got = 0;
    for (int c = 0; c < 12 && !got; c++) begin
      tick();
      if (bus.rdAck) got = 1;
      else if (bus.wrAck != 0) writes++;
    end
`ifdef REGARB_STARVE_GUARD_EN
    check("guard_read_after_4", {got, 8'(writes)}, {1'b1, 8'd4});
`else
    check("starve_no_read", {got, 8'(writes)}, {1'b0, 8'd12});
    bus.wrReq = '0;
    tick();
    check("starve_release", bus.rdAck, 1);
`endif
    idle_inputs();
    tick(); tick(); tick();
    bus.wrReq = 4'b0100; bus.wrAddr = 8'h20; bus.rdReq = 1'b1; bus.rdAddr = 8'h9C;
    tick();
    check("tie_write_first", {bus.wrAck, bus.rdAck}, 5'b01000);
    bus.wrReq = '0;
    tick();
    check("tie_read_next", {bus.rdAck, bus.rfReadSelect}, {1'b1, 8'h9C});
    idle_inputs();
    tick(); tick();
    for (int cyc = 0; cyc < 600; cyc++) begin
      check($sformatf("rand%0d", cyc), dut_obs(), exp_o);
      check($sformatf("excl%0d", cyc), bus.rfWriteEnable & bus.rfReadEnable, 0);
      for (int i = 0; i < 4; i++)
        if (!bus.wrReq[i] || bus.wrAck[i]) begin
          bus.wrReq[i] = $urandom_range(0, 2) != 0;
          bus.wrAddr[i*2 +: 2] = 2'($urandom);
        end
      if (!bus.rdReq || bus.rdAck) begin
        bus.rdReq = $urandom_range(0, 2) == 0;
        bus.rdAddr = 8'($urandom);
      end
      reset = $urandom_range(0, 99) != 0;
      tick();
    end
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule
